// File: rtl/fusion_wb_defs.sv
// Shared encodings and widths for the writeback stage and its load FIFO.
package fusion_wb_defs;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  localparam logic [1:0] WB_MODE_FULL = 2'b00;
  localparam logic [1:0] WB_MODE_UH   = 2'b01;
  localparam logic [1:0] WB_MODE_LH   = 2'b10;
  localparam logic [1:0] WB_MODE_NONE = 2'b11;

  localparam logic [1:0] LD_SZ_B = 2'b00;
  localparam logic [1:0] LD_SZ_H = 2'b01;
  localparam logic [1:0] LD_SZ_W = 2'b10;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       val;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Power-of-two depth synchronous FIFO holding extended load returns.
// Head entry is visible combinationally so the stage can pop and register it in one edge.
module wb_load_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: arbitrates ALU results and extended loads onto the register file write port.
// Optional build macro FUSION_WB_FORWARD_EN adds a bypass copy of full-word writes.
module writeback_stage
  import fusion_wb_defs::*;
#(
  parameter int LD_FIFO_DEPTH = 2,
  parameter bit ZERO_REG_RO   = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  alu_valid_in,
  output logic                  alu_ready_out,
  input  logic [REG_ADDR_W-1:0] alu_rd_in,
  input  logic [XLEN-1:0]       alu_val_in,
  input  logic [1:0]            alu_mode_in,
  input  logic                  ld_valid_in,
  output logic                  ld_ready_out,
  input  logic [REG_ADDR_W-1:0] ld_rd_in,
  input  logic [XLEN-1:0]       ld_val_in,
  input  logic [1:0]            ld_size_in,
  input  logic                  ld_sign_in,
  output logic [XLEN-1:0]       rd_val_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  wb_out,
  output logic                  wb_uh_out,
  output logic                  wb_lh_out
`ifdef FUSION_WB_FORWARD_EN
  ,
  output logic                  fwd_valid_out,
  output logic [REG_ADDR_W-1:0] fwd_rd_out,
  output logic [XLEN-1:0]       fwd_val_out
`endif
);

  localparam int CW = $clog2(LD_FIFO_DEPTH) + 1;

  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                   input logic [1:0] size,
                                                   input logic sgn);
    case (size)
      LD_SZ_B: extend_load = {{(XLEN-8){sgn & raw[7]}}, raw[7:0]};
      LD_SZ_H: extend_load = {{(XLEN-16){sgn & raw[15]}}, raw[15:0]};
      LD_SZ_W: extend_load = raw;
      default: extend_load = raw;
    endcase
  endfunction

  wb_entry_t      push_entry;
  wb_entry_t      head_entry;
  logic [CW-1:0]  ld_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           ld_push;
  logic           grant_alu;
  logic           grant_ld;
  logic           zero_alu;
  logic           zero_ld;

  assign push_entry = '{rd: ld_rd_in, val: extend_load(ld_val_in, ld_size_in, ld_sign_in)};

  assign ld_ready_out  = (ld_count < CW'(LD_FIFO_DEPTH));
  assign alu_ready_out = ~fifo_full;
  assign ld_push       = ld_valid_in & ld_ready_out;

  // A full FIFO takes priority so loads can never starve behind a busy ALU.
  assign grant_alu = ~fifo_full & alu_valid_in;
  assign grant_ld  = fifo_full | (~alu_valid_in & ~fifo_empty);

  assign zero_alu = ZERO_REG_RO && (alu_rd_in == '0);
  assign zero_ld  = ZERO_REG_RO && (head_entry.rd == '0);

  wb_load_fifo #(
    .DEPTH (LD_FIFO_DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_ld_fifo (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .push      (ld_push),
    .push_data (push_entry),
    .pop       (grant_ld),
    .head      (head_entry),
    .count     (ld_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rd_out     <= '0;
      rd_val_out <= '0;
      wb_out     <= 1'b0;
      wb_uh_out  <= 1'b0;
      wb_lh_out  <= 1'b0;
    end else if (grant_alu) begin
      rd_out     <= alu_rd_in;
      rd_val_out <= alu_val_in;
      wb_out     <= (alu_mode_in != WB_MODE_NONE) && !zero_alu;
      wb_uh_out  <= (alu_mode_in == WB_MODE_UH) && !zero_alu;
      wb_lh_out  <= (alu_mode_in == WB_MODE_LH) && !zero_alu;
    end else if (grant_ld) begin
      rd_out     <= head_entry.rd;
      rd_val_out <= head_entry.val;
      wb_out     <= !zero_ld;
      wb_uh_out  <= 1'b0;
      wb_lh_out  <= 1'b0;
    end else begin
      // Idle: address/data hold, only the enables drop.
      wb_out     <= 1'b0;
      wb_uh_out  <= 1'b0;
      wb_lh_out  <= 1'b0;
    end
  end

`ifdef FUSION_WB_FORWARD_EN
  assign fwd_valid_out = wb_out & ~wb_uh_out & ~wb_lh_out;
  assign fwd_rd_out    = rd_out;
  assign fwd_val_out   = rd_val_out;
`endif

endmodule
